// File: rtl/fft_pkg.sv
// Shared constants for the 32-point FFT: default widths, W16 twiddles,
// frame-control state encoding and the butterfly operand addressing.
package fft_pkg;

    localparam int P_IN_REAL_BITS  = 10;
    localparam int P_OUT_REAL_BITS = 12;
    localparam int P_TW_BITS       = 8;
    localparam int P_TW_FRAC_BITS  = 6;

    localparam int N_POINTS = 32;
    localparam int N_LANES  = 4;

    // W16^k = exp(-j*2*pi*k/16) in signed Q1.6
    localparam logic signed [7:0] TW16_RE [0:7] = '{
        8'sd64, 8'sd59, 8'sd45, 8'sd24, 8'sd0, -8'sd24, -8'sd45, -8'sd59
    };
    localparam logic signed [7:0] TW16_IM [0:7] = '{
        8'sd0, -8'sd24, -8'sd45, -8'sd59, -8'sd64, -8'sd59, -8'sd45, -8'sd24
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Butterfly j = 4*cnt + lane lives in group g = cnt[1] with k = {cnt[0], lane}.
    // Its upper operand sits at 16g + k, the lower one 8 points further on.
    function automatic logic [4:0] a_index(input logic [1:0] cnt, input logic [1:0] lane);
        return {cnt[1], 1'b0, cnt[0], lane};
    endfunction

    function automatic logic [4:0] b_index(input logic [1:0] cnt, input logic [1:0] lane);
        return {cnt[1], 1'b1, cnt[0], lane};
    endfunction

    function automatic logic [2:0] tw_index(input logic [1:0] cnt, input logic [1:0] lane);
        return {cnt[0], lane};
    endfunction

endpackage

// File: rtl/stage3_butterfly.sv
// Combinational radix-2 butterfly: d0 = a + W*b, d1 = a - W*b.
// W*b keeps a full-precision product and is floored back by the twiddle
// fraction; the sum/difference width leaves room for the growth, so no
// saturation is needed.
module stage3_butterfly
    import fft_pkg::*;
#(
    parameter int p_inRealBits  = P_IN_REAL_BITS,
    parameter int p_outRealBits = P_OUT_REAL_BITS,
    parameter int p_twBits      = P_TW_BITS,
    parameter int p_twFracBits  = P_TW_FRAC_BITS
) (
    input  logic [2*p_inRealBits-1:0]  i_a,
    input  logic [2*p_inRealBits-1:0]  i_b,
    input  logic signed [p_twBits-1:0] i_wr,
    input  logic signed [p_twBits-1:0] i_wi,
    output logic [2*p_outRealBits-1:0] o_sum,
    output logic [2*p_outRealBits-1:0] o_dif
);

    // One bit wider than a single product so the sum of two products cannot wrap
    localparam int PW = p_inRealBits + p_twBits + 1;
    localparam int IW = p_inRealBits;
    localparam int OW = p_outRealBits;

    logic signed [IW-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
    logic signed [PW-1:0] prod_re, prod_im, shr_re, shr_im;
    logic signed [OW-1:0] a_re_x, a_im_x, wb_re, wb_im;
    logic signed [OW-1:0] sum_re, sum_im, dif_re, dif_im;

    // Complex multiply, floor to integer, then add/subtract against a
    always_comb begin
        a_re = i_a[2*IW-1:IW];
        a_im = i_a[IW-1:0];
        b_re = i_b[2*IW-1:IW];
        b_im = i_b[IW-1:0];

        b_re_x = PW'(b_re);
        b_im_x = PW'(b_im);
        w_re_x = PW'(i_wr);
        w_im_x = PW'(i_wi);

        prod_re = (b_re_x * w_re_x) - (b_im_x * w_im_x);
        prod_im = (b_re_x * w_im_x) + (b_im_x * w_re_x);

        // Arithmetic shift gives truncation toward minus infinity
        shr_re = prod_re >>> p_twFracBits;
        shr_im = prod_im >>> p_twFracBits;

        // The scaled product magnitude is below 2^(OW-1), so narrowing is exact
        wb_re = OW'(shr_re);
        wb_im = OW'(shr_im);

        a_re_x = OW'(a_re);
        a_im_x = OW'(a_im);

        sum_re = a_re_x + wb_re;
        sum_im = a_im_x + wb_im;
        dif_re = a_re_x - wb_re;
        dif_im = a_im_x - wb_im;

        o_sum = {sum_re, sum_im};
        o_dif = {dif_re, dif_im};
    end

endmodule

// File: rtl/stage3_tdm_butterfly.sv
// Third FFT stage: 16 span-8 butterflies on two 16-point groups, folded onto
// four shared lanes over four COMPUTE cycles. A frame is captured, computed
// into the output registers, then held with o_valid until the consumer takes it.
module stage3_tdm_butterfly
    import fft_pkg::*;
#(
    parameter int p_inRealBits  = P_IN_REAL_BITS,
    parameter int p_outRealBits = P_OUT_REAL_BITS,
    parameter int p_twBits      = P_TW_BITS,
    parameter int p_twFracBits  = P_TW_FRAC_BITS
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [2*p_inRealBits-1:0]  i_c0,  i_c1,  i_c2,  i_c3,
    input  logic [2*p_inRealBits-1:0]  i_c4,  i_c5,  i_c6,  i_c7,
    input  logic [2*p_inRealBits-1:0]  i_c8,  i_c9,  i_c10, i_c11,
    input  logic [2*p_inRealBits-1:0]  i_c12, i_c13, i_c14, i_c15,
    input  logic [2*p_inRealBits-1:0]  i_c16, i_c17, i_c18, i_c19,
    input  logic [2*p_inRealBits-1:0]  i_c20, i_c21, i_c22, i_c23,
    input  logic [2*p_inRealBits-1:0]  i_c24, i_c25, i_c26, i_c27,
    input  logic [2*p_inRealBits-1:0]  i_c28, i_c29, i_c30, i_c31,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [2*p_outRealBits-1:0] o_d0,  o_d1,  o_d2,  o_d3,
    output logic [2*p_outRealBits-1:0] o_d4,  o_d5,  o_d6,  o_d7,
    output logic [2*p_outRealBits-1:0] o_d8,  o_d9,  o_d10, o_d11,
    output logic [2*p_outRealBits-1:0] o_d12, o_d13, o_d14, o_d15,
    output logic [2*p_outRealBits-1:0] o_d16, o_d17, o_d18, o_d19,
    output logic [2*p_outRealBits-1:0] o_d20, o_d21, o_d22, o_d23,
    output logic [2*p_outRealBits-1:0] o_d24, o_d25, o_d26, o_d27,
    output logic [2*p_outRealBits-1:0] o_d28, o_d29, o_d30, o_d31
);

    localparam int IW2 = 2 * p_inRealBits;
    localparam int OW2 = 2 * p_outRealBits;

    logic [IW2-1:0] in_vec   [N_POINTS];
    logic [IW2-1:0] in_buf_q [N_POINTS];
    logic [IW2-1:0] in_buf_d [N_POINTS];
    logic [OW2-1:0] out_q    [N_POINTS];
    logic [OW2-1:0] out_d    [N_POINTS];

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [IW2-1:0] lane_a   [N_LANES];
    logic [IW2-1:0] lane_b   [N_LANES];
    logic [OW2-1:0] lane_sum [N_LANES];
    logic [OW2-1:0] lane_dif [N_LANES];

    assign in_vec = '{
        i_c0,  i_c1,  i_c2,  i_c3,  i_c4,  i_c5,  i_c6,  i_c7,
        i_c8,  i_c9,  i_c10, i_c11, i_c12, i_c13, i_c14, i_c15,
        i_c16, i_c17, i_c18, i_c19, i_c20, i_c21, i_c22, i_c23,
        i_c24, i_c25, i_c26, i_c27, i_c28, i_c29, i_c30, i_c31
    };

    assign o_d0  = out_q[0];  assign o_d1  = out_q[1];  assign o_d2  = out_q[2];  assign o_d3  = out_q[3];
    assign o_d4  = out_q[4];  assign o_d5  = out_q[5];  assign o_d6  = out_q[6];  assign o_d7  = out_q[7];
    assign o_d8  = out_q[8];  assign o_d9  = out_q[9];  assign o_d10 = out_q[10]; assign o_d11 = out_q[11];
    assign o_d12 = out_q[12]; assign o_d13 = out_q[13]; assign o_d14 = out_q[14]; assign o_d15 = out_q[15];
    assign o_d16 = out_q[16]; assign o_d17 = out_q[17]; assign o_d18 = out_q[18]; assign o_d19 = out_q[19];
    assign o_d20 = out_q[20]; assign o_d21 = out_q[21]; assign o_d22 = out_q[22]; assign o_d23 = out_q[23];
    assign o_d24 = out_q[24]; assign o_d25 = out_q[25]; assign o_d26 = out_q[26]; assign o_d27 = out_q[27];
    assign o_d28 = out_q[28]; assign o_d29 = out_q[29]; assign o_d30 = out_q[30]; assign o_d31 = out_q[31];

    // Each lane picks its operand pair and twiddle from the current cnt slot
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        logic [2:0] tw_k;

        assign tw_k        = tw_index(cnt_q, 2'(gi));
        assign lane_a[gi]  = in_buf_q[a_index(cnt_q, 2'(gi))];
        assign lane_b[gi]  = in_buf_q[b_index(cnt_q, 2'(gi))];

        stage3_butterfly #(
            .p_inRealBits  (p_inRealBits),
            .p_outRealBits (p_outRealBits),
            .p_twBits      (p_twBits),
            .p_twFracBits  (p_twFracBits)
        ) u_bfly (
            .i_a   (lane_a[gi]),
            .i_b   (lane_b[gi]),
            .i_wr  (p_twBits'(TW16_RE[tw_k])),
            .i_wi  (p_twBits'(TW16_IM[tw_k])),
            .o_sum (lane_sum[gi]),
            .o_dif (lane_dif[gi])
        );
    end

    // Frame control: capture, four compute slots, then hold until taken
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_buf_d = in_buf_q;
        out_d    = out_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    in_buf_d = in_vec;
                    cnt_d    = 2'd0;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int l = 0; l < N_LANES; l++) begin
                    out_d[a_index(cnt_q, 2'(l))] = lane_sum[l];
                    out_d[b_index(cnt_q, 2'(l))] = lane_dif[l];
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    if (i_valid) begin
                        in_buf_d = in_vec;
                        cnt_d    = 2'd0;
                        state_d  = COMPUTE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, input buffer and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            for (int i = 0; i < N_POINTS; i++) begin
                in_buf_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_buf_q <= in_buf_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_stage3_tdm_butterfly.sv
// Directed bench for stage3_tdm_butterfly: reset, impulses, truncation,
// extremes, backpressure and streaming, one transaction line each.
module tb_stage3_tdm_butterfly;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [19:0] c_in  [32];
    logic [23:0] d_out [32];
    logic [23:0] exp_d [32];

    int n_checks;
    int n_pass;

    stage3_tdm_butterfly dut (
        .CLK(clk), .RST(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_c0(c_in[0]),   .i_c1(c_in[1]),   .i_c2(c_in[2]),   .i_c3(c_in[3]),
        .i_c4(c_in[4]),   .i_c5(c_in[5]),   .i_c6(c_in[6]),   .i_c7(c_in[7]),
        .i_c8(c_in[8]),   .i_c9(c_in[9]),   .i_c10(c_in[10]), .i_c11(c_in[11]),
        .i_c12(c_in[12]), .i_c13(c_in[13]), .i_c14(c_in[14]), .i_c15(c_in[15]),
        .i_c16(c_in[16]), .i_c17(c_in[17]), .i_c18(c_in[18]), .i_c19(c_in[19]),
        .i_c20(c_in[20]), .i_c21(c_in[21]), .i_c22(c_in[22]), .i_c23(c_in[23]),
        .i_c24(c_in[24]), .i_c25(c_in[25]), .i_c26(c_in[26]), .i_c27(c_in[27]),
        .i_c28(c_in[28]), .i_c29(c_in[29]), .i_c30(c_in[30]), .i_c31(c_in[31]),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_d0(d_out[0]),   .o_d1(d_out[1]),   .o_d2(d_out[2]),   .o_d3(d_out[3]),
        .o_d4(d_out[4]),   .o_d5(d_out[5]),   .o_d6(d_out[6]),   .o_d7(d_out[7]),
        .o_d8(d_out[8]),   .o_d9(d_out[9]),   .o_d10(d_out[10]), .o_d11(d_out[11]),
        .o_d12(d_out[12]), .o_d13(d_out[13]), .o_d14(d_out[14]), .o_d15(d_out[15]),
        .o_d16(d_out[16]), .o_d17(d_out[17]), .o_d18(d_out[18]), .o_d19(d_out[19]),
        .o_d20(d_out[20]), .o_d21(d_out[21]), .o_d22(d_out[22]), .o_d23(d_out[23]),
        .o_d24(d_out[24]), .o_d25(d_out[25]), .o_d26(d_out[26]), .o_d27(d_out[27]),
        .o_d28(d_out[28]), .o_d29(d_out[29]), .o_d30(d_out[30]), .o_d31(d_out[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pk10(input int re, input int im);
        logic [31:0] r;
        logic [31:0] m;
        r = re;
        m = im;
        return {r[9:0], m[9:0]};
    endfunction

    function automatic logic [23:0] pk12(input int re, input int im);
        logic [31:0] r;
        logic [31:0] m;
        r = re;
        m = im;
        return {r[11:0], m[11:0]};
    endfunction

    task automatic clear_vectors;
        for (int i = 0; i < 32; i++) begin
            c_in[i]  = '0;
            exp_d[i] = '0;
        end
    endtask

    // Offer c_in while IDLE, then count edges until o_valid (bounded)
    task automatic send_and_wait(output int lat);
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_output;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        clear_vectors();
        c_in[8] = pk10(100, 0);
        rst = 1'b0;
        i_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_o_ready got %b want 1", o_ready); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== 24'h0) $display("FAIL reset_d%0d got %h want 000000", i, d_out[i]); else n_pass++;
        end
        i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_no_capture o_ready got %b want 1", o_ready); else n_pass++;
        $display("reset: idle after release, o_ready=%b", o_ready);

        // Accept a frame, then reset one cycle into COMPUTE
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        n_checks++; if (o_ready !== 1'b0) $display("FAIL compute_o_ready got %b want 0", o_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (d_out[0] !== pk12(100, 0)) $display("FAIL partial_d0 got %h want %h", d_out[0], pk12(100, 0)); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL midreset_o_valid got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL midreset_o_ready got %b want 1", o_ready); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== 24'h0) $display("FAIL midreset_d%0d got %h want 000000", i, d_out[i]); else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("reset: mid-compute reset cleared outputs");
    endtask

    task automatic test_impulse;
        int lat;
        clear_vectors();
        c_in[8]  = pk10(100, 0);
        exp_d[0] = pk12(100, 0);
        exp_d[8] = pk12(-100, 0);
        send_and_wait(lat);
        n_checks++; if (lat !== 4) $display("FAIL impulse_c8_latency got %0d want 4", lat); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== exp_d[i]) $display("FAIL impulse_c8_d%0d got %h want %h", i, d_out[i], exp_d[i]); else n_pass++;
        end
        take_output();
        n_checks++; if (o_valid !== 1'b0) $display("FAIL impulse_c8_o_valid_fall got %b want 0", o_valid); else n_pass++;
        $display("impulse c8=(100,0): latency %0d, d0=%h d8=%h", lat, d_out[0], d_out[8]);

        clear_vectors();
        c_in[9]  = pk10(64, 0);
        exp_d[1] = pk12(59, -24);
        exp_d[9] = pk12(-59, 24);
        send_and_wait(lat);
        n_checks++; if (lat !== 4) $display("FAIL impulse_c9_latency got %0d want 4", lat); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== exp_d[i]) $display("FAIL impulse_c9_d%0d got %h want %h", i, d_out[i], exp_d[i]); else n_pass++;
        end
        take_output();
        $display("impulse c9=(64,0): d1=%h d9=%h", d_out[1], d_out[9]);
    endtask

    task automatic test_truncation;
        int lat;
        clear_vectors();
        c_in[9]  = pk10(-1, 0);
        exp_d[1] = pk12(-1, 0);
        exp_d[9] = pk12(1, 0);
        send_and_wait(lat);
        n_checks++; if (lat !== 4) $display("FAIL trunc_latency got %0d want 4", lat); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== exp_d[i]) $display("FAIL trunc_d%0d got %h want %h", i, d_out[i], exp_d[i]); else n_pass++;
        end
        take_output();
        $display("truncation c9=(-1,0): d1=%h d9=%h", d_out[1], d_out[9]);
    endtask

    task automatic test_extremes;
        int lat;
        for (int g = 0; g < 2; g++) begin
            clear_vectors();
            c_in[3 + 16*g]   = pk10(511, 511);
            c_in[11 + 16*g]  = pk10(511, -511);
            exp_d[3 + 16*g]  = pk12(231, -152);
            exp_d[11 + 16*g] = pk12(791, 1174);
            send_and_wait(lat);
            n_checks++; if (lat !== 4) $display("FAIL extreme_g%0d_latency got %0d want 4", g, lat); else n_pass++;
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (d_out[i] !== exp_d[i]) $display("FAIL extreme_g%0d_d%0d got %h want %h", g, i, d_out[i], exp_d[i]); else n_pass++;
            end
            take_output();
            $display("extremes group %0d: d%0d=%h d%0d=%h", g, 3 + 16*g, d_out[3 + 16*g], 11 + 16*g, d_out[11 + 16*g]);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        clear_vectors();
        c_in[8]  = pk10(100, 0);
        exp_d[0] = pk12(100, 0);
        exp_d[8] = pk12(-100, 0);
        send_and_wait(lat);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_first_valid got %b want 1", o_valid); else n_pass++;

        // Next frame offered while the consumer stalls
        for (int i = 0; i < 32; i++) c_in[i] = '0;
        c_in[9] = pk10(64, 0);
        i_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_hold_valid cyc%0d got %b want 1", cyc, o_valid); else n_pass++;
            n_checks++; if (o_ready !== 1'b0) $display("FAIL bp_hold_ready cyc%0d got %b want 0", cyc, o_ready); else n_pass++;
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (d_out[i] !== exp_d[i]) $display("FAIL bp_hold_cyc%0d_d%0d got %h want %h", cyc, i, d_out[i], exp_d[i]); else n_pass++;
            end
        end
        $display("backpressure: 10 stalled cycles, outputs held");

        i_ready = 1'b1;
        #1;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", o_ready); else n_pass++;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        lat = 0;
        while (!o_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 4) $display("FAIL bp_new_latency got %0d want 4", lat); else n_pass++;
        for (int i = 0; i < 32; i++) exp_d[i] = '0;
        exp_d[1] = pk12(59, -24);
        exp_d[9] = pk12(-59, 24);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (d_out[i] !== exp_d[i]) $display("FAIL bp_new_d%0d got %h want %h", i, d_out[i], exp_d[i]); else n_pass++;
        end
        take_output();
        $display("backpressure: new frame after %0d cycles, d1=%h", lat, d_out[1]);
    endtask

    // Streaming frames are single impulses: an upper-operand impulse copies to
    // both outputs; a lower-operand impulse at k=0 gives (+v, -v).
    int s_idx [8] = '{0, 1, 2, 3, 16, 21, 0, 16};
    bit s_low [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int s_re  [8] = '{11, -22, 33, -44, 55, -66, 77, -88};
    int s_im  [8] = '{-5, 6, -7, 8, -9, 10, -11, 12};

    task automatic set_stream_input(input int f);
        for (int i = 0; i < 32; i++) c_in[i] = '0;
        c_in[s_idx[f] + (s_low[f] ? 8 : 0)] = pk10(s_re[f], s_im[f]);
    endtask

    task automatic set_stream_expect(input int f);
        for (int i = 0; i < 32; i++) exp_d[i] = '0;
        exp_d[s_idx[f]] = pk12(s_re[f], s_im[f]);
        exp_d[s_idx[f] + 8] = s_low[f] ? pk12(-s_re[f], -s_im[f]) : pk12(s_re[f], s_im[f]);
    endtask

    task automatic test_streaming;
        int  in_idx;
        int  out_idx;
        int  last_cyc;
        int  dup;
        bit  acc;
        clear_vectors();
        set_stream_input(0);
        in_idx   = 0;
        out_idx  = 0;
        last_cyc = -1;
        i_valid  = 1'b1;
        i_ready  = 1'b1;
        for (int cyc = 0; cyc < 80 && out_idx < 8; cyc++) begin
            acc = o_ready && i_valid;
            @(posedge clk); #1;
            if (acc) begin
                in_idx++;
                if (in_idx < 8) set_stream_input(in_idx);
                else i_valid = 1'b0;
            end
            if (o_valid) begin
                set_stream_expect(out_idx);
                for (int i = 0; i < 32; i++) begin
                    n_checks++;
                    if (d_out[i] !== exp_d[i]) $display("FAIL stream_f%0d_d%0d got %h want %h", out_idx, i, d_out[i], exp_d[i]); else n_pass++;
                end
                if (out_idx > 0) begin
                    n_checks++;
                    if (cyc - last_cyc !== 5) $display("FAIL stream_f%0d_interval got %0d want 5", out_idx, cyc - last_cyc); else n_pass++;
                end
                $display("stream frame %0d out at cycle %0d: d%0d=%h", out_idx, cyc, s_idx[out_idx], d_out[s_idx[out_idx]]);
                last_cyc = cyc;
                out_idx++;
            end
        end
        n_checks++; if (out_idx !== 8) $display("FAIL stream_frame_count got %0d want 8", out_idx); else n_pass++;
        i_valid = 1'b0;
        dup = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_valid) dup++;
        end
        i_ready = 1'b0;
        n_checks++; if (dup !== 0) $display("FAIL stream_extra_frames got %0d want 0", dup); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        clear_vectors();
        test_reset();
        test_impulse();
        test_truncation();
        test_extremes();
        test_backpressure();
        test_streaming();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
